xc_sha2_sigma_unit: RTL
=======================

# xc_sha2_sigma_unit

Multi-cycle functional unit that evaluates the four SHA-2 sigma functions (σ0, σ1, Σ0, Σ1) for SHA-256 (32-bit) and, when enabled, SHA-512 (64-bit, delivered as two 32-bit halves). It sits in the execute stage beside the ALU and serves the xc.sha256.s0..s3 and xc.sha512.s0..s3 instructions. Operands are accepted and results returned over valid/ready handshakes. SHA-512 operations reuse one 32-bit half-datapath over two cycles.

## Interface
- SHA512_EN, 1: 1 = SHA-512 ops supported; 0 = SHA-512 ops flagged illegal and the high-half datapath/state is removed.
- OUT_REG, 1: 1 = result held in output flops; 0 = result driven combinationally from the final compute cycle, saving one cycle.
- g_clk  in  1  clock, rising edge.
- g_resetn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort; highest priority.
- in_valid  in  1  operand offer.
- in_ready  out  1  unit can accept an op this cycle.
- op  in  3  [2]=0 SHA-256, [2]=1 SHA-512; [1:0]: 0=σ0, 1=σ1, 2=Σ0, 3=Σ1.
- rs1  in  32  SHA-256 operand, or SHA-512 low word.
- rs2  in  32  SHA-512 high word; ignored for SHA-256.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  32  SHA-256 result, or SHA-512 low word.
- result_hi  out  32  SHA-512 high word; 0 for SHA-256.
- illegal  out  1  qualifies out_valid: op[2]=1 with SHA512_EN=0.

## Operation
- Functions, ROR/SHR on the operand width. SHA-256:
  - σ0 = ROR7^ROR18^SHR3; σ1 = ROR17^ROR19^SHR10.
  - Σ0 = ROR2^ROR13^ROR22; Σ1 = ROR6^ROR11^ROR25.
- SHA-512 on {rs2,rs1}:
  - σ0 = ROR1^ROR8^SHR7; σ1 = ROR19^ROR61^SHR6.
  - Σ0 = ROR28^ROR34^ROR39; Σ1 = ROR14^ROR18^ROR41.
- Accept on in_valid & in_ready. op, rs1 and rs2 are latched into operand registers, so inputs may change after the accept.
- FSM states: IDLE, CALC_LO, CALC_HI, DONE.
  - IDLE→CALC_LO on accept.
  - CALC_LO→DONE if SHA-256 or illegal; otherwise CALC_LO→CALC_HI.
  - CALC_HI→DONE.
  - DONE→IDLE on out_ready without a new accept.
  - DONE→CALC_LO on out_ready with a new accept.
- Half-datapath: CALC_LO computes result bits [31:0]; CALC_HI computes bits [63:32]. Both read the full latched 64-bit operand, so each half's funnel shift sees both words.
- SHA-256 results place 0 on result_hi. Illegal ops return result=0, result_hi=0, illegal=1.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Back-to-back ops therefore incur no bubble.
- out_valid = (state==DONE) when OUT_REG=1. With OUT_REG=0, out_valid is asserted in the final compute state and result is taken from the datapath directly.
- result, result_hi and illegal are held stable while out_valid & !out_ready.
- flush: state→IDLE next cycle, out_valid low next cycle, any in-flight or pending result discarded. An in_valid in the same cycle as flush is not accepted (in_ready forced 0).

## Timing
- Reset (async assert, sync release) state:
  - state=IDLE, out_valid=0, in_ready=1.
  - result=0, result_hi=0, illegal=0.
  - operand registers 0.
- Latency from accept at cycle N, OUT_REG=1:
  - SHA-256 or illegal: out_valid at N+2.
  - SHA-512: out_valid at N+3.
- Latency with OUT_REG=0: one cycle less for each case.
- Throughput with out_ready held high:
  - SHA-256: 1 op per 2 cycles (OUT_REG=1), 1 op per cycle (OUT_REG=0).
  - SHA-512: one additional cycle per op.
- Reset asserted mid-operation: all outputs reach reset values asynchronously; no partial result is ever presented.
- Simultaneous out_ready and in_valid in DONE: the result retires and the new op is accepted in the same cycle.
- Simultaneous flush and out_ready in DONE: flush wins; the result is treated as consumed and dropped.

## Test plan
- SHA-256 Σ1 (op=3), rs1=0x00000001 → result=0x04200080, result_hi=0, illegal=0, out_valid at N+2.
- SHA-256 σ0 (op=0), rs1=0x00000001 → result=0x02004000. A second op offered while out_ready=1 is accepted that same cycle, with no bubble.
- SHA-512 Σ0 (op=6), {rs2,rs1}=0x0000000000000001 → result=0x42000000, result_hi=0x00000010 at N+3.
- SHA-512 σ1 (op=5), rs2=0x80000000, rs1=0 → result=0x00000004, result_hi=0x02001000. Hold out_ready=0 for 5 cycles → outputs stable and in_ready=0 throughout.
- SHA512_EN=0, op=4 → out_valid at N+2 with illegal=1 and result=0. Flush asserted in CALC_HI (SHA512_EN=1) → out_valid never rises and state is IDLE next cycle.
- Deassert g_resetn in CALC_LO → out_valid=0 and result=0 immediately. Release reset → in_ready=1 and the next op completes normally.

Source files
------------

// File: rtl/xc_sha2_sigma_unit.sv
// xc_sha2_sigma_unit
// Multi-cycle SHA-2 sigma unit (sigma0/sigma1/Sigma0/Sigma1) for SHA-256 and,
// optionally, SHA-512. SHA-512 results are produced by one 32-bit
// half-datapath over two cycles: low word first, then high word.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no operation held; ready for a new op
// CALC_LO | computing result bits [31:0] (sole compute cycle for SHA-256/illegal)
// CALC_HI | computing result bits [63:32] of a SHA-512 op
// DONE    | result held in output registers until out_ready
module xc_sha2_sigma_unit #(
    parameter logic SHA512_EN = 1'b1,
    parameter logic OUT_REG   = 1'b1
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [31:0] result_hi,
    output logic        illegal
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CALC_LO = 2'd1,
        CALC_HI = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [2:0]  op_q;
    logic [31:0] opnd_lo_q;
    logic [31:0] opnd_hi_q;
    logic [31:0] res_lo_q;
    logic [31:0] res_hi_q;
    logic        ill_q;

    logic        is_512;
    logic        op_illegal;
    logic        final_calc;
    logic        accept;

    logic [5:0]  sh1;
    logic [5:0]  sh2;
    logic [5:0]  sh3;
    logic        last_shr;

    logic [31:0] dp_a;
    logic [31:0] dp_b_ror;
    logic [31:0] dp_b_shr;
    logic [31:0] dp_t3;
    logic [31:0] dp_out;

    logic [31:0] nxt_lo;
    logic [31:0] nxt_hi;
    logic        nxt_ill;

    // Low 32 bits of a 64-bit rotate-right of w by k.
    function automatic logic [31:0] ror_lo(input logic [63:0] w, input logic [5:0] k);
        logic [127:0] d;
        d = {w, w};
        return d[k +: 32];
    endfunction

    // Low 32 bits of a 64-bit logical shift-right of w by k.
    function automatic logic [31:0] shr_lo(input logic [63:0] w, input logic [5:0] k);
        logic [95:0] d;
        d = {32'd0, w};
        return d[k +: 32];
    endfunction

    // Illegal ops take the SHA-256 path for timing; their result is forced to 0.
    assign is_512     = op_q[2] & SHA512_EN;
    assign op_illegal = op_q[2] & ~SHA512_EN;
    assign final_calc = ((state_q == CALC_LO) && !is_512) || (state_q == CALC_HI);

    // Without output registers the result is visible in the last compute cycle.
    assign out_valid  = (state_q == DONE) || (!OUT_REG && final_calc);
    assign in_ready   = !flush && ((state_q == IDLE) || (out_valid && out_ready));
    assign accept     = in_valid && in_ready;

    // Shift/rotate amounts; the third term is a shift for the small sigmas.
    always_comb begin
        sh1      = 6'd0;
        sh2      = 6'd0;
        sh3      = 6'd0;
        last_shr = 1'b0;
        case ({is_512, op_q[1:0]})
            3'b000: begin sh1 = 6'd7;  sh2 = 6'd18; sh3 = 6'd3;  last_shr = 1'b1; end
            3'b001: begin sh1 = 6'd17; sh2 = 6'd19; sh3 = 6'd10; last_shr = 1'b1; end
            3'b010: begin sh1 = 6'd2;  sh2 = 6'd13; sh3 = 6'd22; end
            3'b011: begin sh1 = 6'd6;  sh2 = 6'd11; sh3 = 6'd25; end
            3'b100: begin sh1 = 6'd1;  sh2 = 6'd8;  sh3 = 6'd7;  last_shr = 1'b1; end
            3'b101: begin sh1 = 6'd19; sh2 = 6'd61; sh3 = 6'd6;  last_shr = 1'b1; end
            3'b110: begin sh1 = 6'd28; sh2 = 6'd34; sh3 = 6'd39; end
            default: begin sh1 = 6'd14; sh2 = 6'd18; sh3 = 6'd41; end
        endcase
    end

    // Funnel operands for the half-datapath. A SHA-256 word rotates against
    // itself; for the SHA-512 high half the words are swapped (a 32-bit
    // pre-rotation) and the shift fills with zeros above the operand.
    always_comb begin
        dp_a     = opnd_lo_q;
        dp_b_ror = opnd_lo_q;
        dp_b_shr = 32'd0;
        if (is_512) begin
            if (state_q == CALC_HI) begin
                dp_a     = opnd_hi_q;
                dp_b_ror = opnd_lo_q;
                dp_b_shr = 32'd0;
            end else begin
                dp_a     = opnd_lo_q;
                dp_b_ror = opnd_hi_q;
                dp_b_shr = opnd_hi_q;
            end
        end
    end

    assign dp_t3  = last_shr ? shr_lo({dp_b_shr, dp_a}, sh3)
                             : ror_lo({dp_b_ror, dp_a}, sh3);
    assign dp_out = ror_lo({dp_b_ror, dp_a}, sh1) ^ ror_lo({dp_b_ror, dp_a}, sh2) ^ dp_t3;

    // Values the result registers take at the end of this cycle.
    always_comb begin
        nxt_lo  = res_lo_q;
        nxt_hi  = res_hi_q;
        nxt_ill = ill_q;
        case (state_q)
            CALC_LO: begin
                nxt_lo  = op_illegal ? 32'd0 : dp_out;
                nxt_hi  = 32'd0;
                nxt_ill = op_illegal;
            end
            CALC_HI: begin
                nxt_hi  = dp_out;
                nxt_ill = 1'b0;
            end
            default: ;
        endcase
    end

    assign result    = (!OUT_REG && final_calc) ? nxt_lo  : res_lo_q;
    assign result_hi = (!OUT_REG && final_calc) ? nxt_hi  : res_hi_q;
    assign illegal   = (!OUT_REG && final_calc) ? nxt_ill : ill_q;

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) state_d = CALC_LO;
                end
                CALC_LO: begin
                    if (is_512)          state_d = CALC_HI;
                    else if (OUT_REG)    state_d = DONE;
                    else if (out_ready)  state_d = accept ? CALC_LO : IDLE;
                    else                 state_d = DONE;
                end
                CALC_HI: begin
                    if (OUT_REG)         state_d = DONE;
                    else if (out_ready)  state_d = accept ? CALC_LO : IDLE;
                    else                 state_d = DONE;
                end
                DONE: begin
                    if (out_ready) state_d = accept ? CALC_LO : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Operand capture on accept so the issuing stage may move on.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            op_q      <= 3'd0;
            opnd_lo_q <= 32'd0;
            opnd_hi_q <= 32'd0;
        end else if (accept) begin
            op_q      <= op;
            opnd_lo_q <= rs1;
            opnd_hi_q <= SHA512_EN ? rs2 : 32'd0;
        end
    end

    // Result registers; they hold while no compute state is active.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            res_lo_q <= 32'd0;
            res_hi_q <= 32'd0;
            ill_q    <= 1'b0;
        end else begin
            res_lo_q <= nxt_lo;
            res_hi_q <= SHA512_EN ? nxt_hi : 32'd0;
            ill_q    <= nxt_ill;
        end
    end

endmodule
